// File: rtl/gamma_lut_update_ctrl.sv
// Gamma LUT update sequencer.
// A host queues (address, value) pairs in a small FIFO and then commits the batch. The batch
// is written into the LUT RAM only during write windows (vertical blanking with no valid
// pixel), one entry per cycle. Outside a drain the RAM address port carries the pixel lookup.
//
// Ports:
//   pixclk, resetb        - clock, asynchronous active-low reset
//   upd_valid/ready/addr/data - host update entry handshake
//   commit                - single-cycle request to apply the queued batch
//   blank, dvi, y         - video timing and pixel lookup index
//   ram_addr/we/datao     - registered LUT RAM port
//   busy, level           - controller state (non-idle) and FIFO occupancy
//   commit_done           - one-cycle pulse with the final write of a batch
module gamma_lut_update_ctrl #(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned FIFO_AW     = 4
) (
  input  logic                   pixclk,
  input  logic                   resetb,
  input  logic                   upd_valid,
  output logic                   upd_ready,
  input  logic [ADDR_WIDTH-1:0]  upd_addr,
  input  logic [PIXEL_WIDTH-1:0] upd_data,
  input  logic                   commit,
  input  logic                   blank,
  input  logic                   dvi,
  input  logic [PIXEL_WIDTH-1:0] y,
  output logic [ADDR_WIDTH-1:0]  ram_addr,
  output logic                   ram_we,
  output logic [PIXEL_WIDTH-1:0] ram_datao,
  output logic                   busy,
  output logic [FIFO_AW:0]       level,
  output logic                   commit_done
);

  typedef enum logic [1:0] {StIdle, StArmed, StDrain} state_e;

  localparam logic [FIFO_AW:0]   FullLevel = (FIFO_AW + 1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0]   OneLevel  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PtrOne    = FIFO_AW'(1);

  state_e                 state_q, state_d;
  logic [FIFO_AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]       count_q, count_d;
  logic [ADDR_WIDTH-1:0]  ram_addr_q, ram_addr_d;
  logic                   ram_we_q, ram_we_d;
  logic [PIXEL_WIDTH-1:0] ram_datao_q, ram_datao_d;
  logic                   commit_done_q, commit_done_d;

  logic [ADDR_WIDTH-1:0]  fifo_addr_q [FIFO_DEPTH];
  logic [PIXEL_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];

  logic             win;
  logic             push;
  logic             pop;
  logic             last_pop;
  logic [FIFO_AW:0] post_push_level;

  assign win       = blank & ~dvi;
  assign upd_ready = (state_q == StIdle) && (count_q < FullLevel);
  assign push      = upd_valid & upd_ready;
  // ARMED and DRAIN always hold at least one entry, so any window there pops.
  assign pop       = (state_q != StIdle) && win;
  assign last_pop  = pop && (count_q == OneLevel);
  assign post_push_level = push ? (count_q + OneLevel) : count_q;

  always_comb begin
    state_d       = state_q;
    commit_done_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (commit) begin
          if (post_push_level != '0) begin
            state_d = StArmed;
          end else begin
            commit_done_d = 1'b1;
          end
        end
      end
      StArmed, StDrain: begin
        if (pop) begin
          state_d = last_pop ? StIdle : StDrain;
          // Registered alongside ram_we so the pulse coincides with the final write.
          commit_done_d = last_pop;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
      count_d  = count_q + OneLevel;
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
      count_d  = count_q - OneLevel;
    end
  end

  // Writes only follow a window cycle, so they never overlap a dvi-qualified lookup.
  always_comb begin
    ram_addr_d  = ADDR_WIDTH'(y);
    ram_we_d    = 1'b0;
    ram_datao_d = ram_datao_q;
    if (pop) begin
      ram_addr_d  = fifo_addr_q[rd_ptr_q];
      ram_we_d    = 1'b1;
      ram_datao_d = fifo_data_q[rd_ptr_q];
    end
  end

  always_ff @(posedge pixclk or negedge resetb) begin
    if (!resetb) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ram_addr_q    <= '0;
      ram_we_q      <= 1'b0;
      ram_datao_q   <= '0;
      commit_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      ram_addr_q    <= ram_addr_d;
      ram_we_q      <= ram_we_d;
      ram_datao_q   <= ram_datao_d;
      commit_done_q <= commit_done_d;
    end
  end

  // Storage needs no reset: contents are only read below the occupancy count.
  always_ff @(posedge pixclk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= upd_addr;
      fifo_data_q[wr_ptr_q] <= upd_data;
    end
  end

  assign ram_addr    = ram_addr_q;
  assign ram_we      = ram_we_q;
  assign ram_datao   = ram_datao_q;
  assign busy        = (state_q != StIdle);
  assign level       = count_q;
  assign commit_done = commit_done_q;

endmodule

// File: tb/tb_gamma_lut_update_ctrl.sv
module tb_gamma_lut_update_ctrl;

  localparam int AW = 10;
  localparam int PW = 8;

  logic          pixclk = 1'b0;
  logic          resetb = 1'b0;
  logic          upd_valid = 1'b0;
  logic          upd_ready;
  logic [AW-1:0] upd_addr = '0;
  logic [PW-1:0] upd_data = '0;
  logic          commit = 1'b0;
  logic          blank = 1'b0;
  logic          dvi = 1'b0;
  logic [PW-1:0] y = '0;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [PW-1:0] ram_datao;
  logic          busy;
  logic [4:0]    level;
  logic          commit_done;

  int checks = 0;
  int errors = 0;

  logic [AW+PW-1:0] sb [$];
  logic [AW+PW-1:0] mon_exp;

  gamma_lut_update_ctrl #(
    .PIXEL_WIDTH(PW),
    .ADDR_WIDTH (AW),
    .FIFO_DEPTH (16),
    .FIFO_AW    (4)
  ) dut (
    .pixclk     (pixclk),
    .resetb     (resetb),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_addr   (upd_addr),
    .upd_data   (upd_data),
    .commit     (commit),
    .blank      (blank),
    .dvi        (dvi),
    .y          (y),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_datao  (ram_datao),
    .busy       (busy),
    .level      (level),
    .commit_done(commit_done)
  );

  always #5 pixclk = ~pixclk;

  // Every presented write must match the oldest queued expectation.
  always @(negedge pixclk) begin
    if (resetb && ram_we) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=0x%0h, required no write",
                 ram_addr, ram_datao);
      end else begin
        mon_exp = sb.pop_front();
        if ({ram_addr, ram_datao} !== mon_exp) begin
          errors++;
          $display("FAIL write_order: got addr=%0d data=0x%0h, required addr=%0d data=0x%0h",
                   ram_addr, ram_datao, mon_exp[AW+PW-1:PW], mon_exp[PW-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge pixclk);
    #1;
  endtask

  task automatic push_entry(input logic [AW-1:0] a, input logic [PW-1:0] d);
    upd_valid = 1'b1;
    upd_addr  = a;
    upd_data  = d;
    tick();
    upd_valid = 1'b0;
    sb.push_back({a, d});
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({ram_addr, ram_we, ram_datao, commit_done, busy, level} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%0d we=%0b data=0x%0h done=%0b busy=%0b level=%0d, required all 0",
               ram_addr, ram_we, ram_datao, commit_done, busy, level);
    end
    @(negedge pixclk);
    resetb = 1'b1;
    tick();
    checks++;
    if (upd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %0b, required 1", upd_ready);
    end
  endtask

  task automatic test_basic_batch();
    push_entry(10'd3, 8'h11);
    push_entry(10'd700, 8'h22);
    push_entry(10'd3, 8'h33);
    do_commit();
    checks++;
    if (busy !== 1'b1 || level !== 5'd3) begin
      errors++;
      $display("FAIL basic_armed: got busy=%0b level=%0d, required busy=1 level=3", busy, level);
    end
    blank = 1'b1;
    dvi   = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (ram_we !== 1'b1 || commit_done !== (i == 3)) begin
        errors++;
        $display("FAIL basic_write%0d: got we=%0b done=%0b, required we=1 done=%0b",
                 i, ram_we, commit_done, (i == 3));
      end
    end
    blank = 1'b0;
    tick();
    checks++;
    if (commit_done !== 1'b0 || busy !== 1'b0 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL basic_after: got done=%0b busy=%0b we=%0b, required 0 0 0",
               commit_done, busy, ram_we);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 6; i++) push_entry(AW'(40 + i), PW'(8'hC0 + i));
    do_commit();
    blank = 1'b1;
    dvi   = 1'b0;
    tick();
    tick();
    blank = 1'b0;
    dvi   = 1'b1;
    y     = 8'h80;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (ram_addr !== 10'h080 || ram_we !== 1'b0 || busy !== 1'b1 || level !== 5'd4) begin
        errors++;
        $display("FAIL stall_cycle%0d: got addr=0x%0h we=%0b busy=%0b level=%0d, required 0x80 0 1 4",
                 i, ram_addr, ram_we, busy, level);
      end
    end
    blank = 1'b1;
    dvi   = 1'b0;
    y     = 8'h00;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (ram_we !== 1'b1 || commit_done !== (i == 4)) begin
        errors++;
        $display("FAIL stall_resume%0d: got we=%0b done=%0b, required we=1 done=%0b",
                 i, ram_we, commit_done, (i == 4));
      end
    end
    blank = 1'b0;
    tick();
  endtask

  task automatic test_full_fifo();
    bit done;
    for (int i = 0; i < 16; i++) push_entry(AW'(500 + 7 * i), PW'(i * 3 + 1));
    checks++;
    if (upd_ready !== 1'b0 || level !== 5'd16) begin
      errors++;
      $display("FAIL full_state: got ready=%0b level=%0d, required ready=0 level=16",
               upd_ready, level);
    end
    upd_valid = 1'b1;
    upd_addr  = 10'd1;
    upd_data  = 8'hEE;
    tick();
    tick();
    checks++;
    if (level !== 5'd16) begin
      errors++;
      $display("FAIL full_hold: got level=%0d, required 16", level);
    end
    upd_valid = 1'b0;
    do_commit();
    blank = 1'b1;
    done  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (commit_done) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL full_drain_timeout: got no commit_done, required commit_done within 40 cycles");
    end
    blank = 1'b0;
    tick();
    checks++;
    if (sb.size() != 0 || level !== 5'd0) begin
      errors++;
      $display("FAIL full_drain_left: got %0d pending level=%0d, required 0 0", sb.size(), level);
    end
  endtask

  task automatic test_empty_commit();
    do_commit();
    checks++;
    if (commit_done !== 1'b1 || busy !== 1'b0 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL empty_commit: got done=%0b busy=%0b we=%0b, required 1 0 0",
               commit_done, busy, ram_we);
    end
    tick();
    checks++;
    if (commit_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_after: got done=%0b busy=%0b, required 0 0", commit_done, busy);
    end
  endtask

  task automatic test_push_commit();
    upd_valid = 1'b1;
    upd_addr  = 10'd9;
    upd_data  = 8'h5A;
    commit    = 1'b1;
    tick();
    upd_valid = 1'b0;
    commit    = 1'b0;
    sb.push_back({10'd9, 8'h5A});
    checks++;
    if (busy !== 1'b1 || level !== 5'd1) begin
      errors++;
      $display("FAIL pc_armed: got busy=%0b level=%0d, required busy=1 level=1", busy, level);
    end
    tick();
    blank = 1'b1;
    tick();
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 10'd9 || ram_datao !== 8'h5A || commit_done !== 1'b1) begin
      errors++;
      $display("FAIL pc_write: got we=%0b addr=%0d data=0x%0h done=%0b, required 1 9 0x5a 1",
               ram_we, ram_addr, ram_datao, commit_done);
    end
    blank = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL pc_idle: got busy=%0b, required 0", busy);
    end
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 8; i++) push_entry(AW'(100 + i), PW'(8'hA0 + i));
    do_commit();
    blank = 1'b1;
    tick();
    tick();
    tick();
    blank = 1'b0;
    dvi   = 1'b1;
    tick();
    checks++;
    if (level !== 5'd5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_level: got level=%0d busy=%0b, required 5 1", level, busy);
    end
    resetb = 1'b0;
    #1;
    checks++;
    if ({ram_addr, ram_we, ram_datao, commit_done, busy, level} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got addr=%0d we=%0b data=0x%0h done=%0b busy=%0b level=%0d, required all 0",
               ram_addr, ram_we, ram_datao, commit_done, busy, level);
    end
    sb.delete();
    dvi = 1'b0;
    @(negedge pixclk);
    resetb = 1'b1;
    tick();
    checks++;
    if (upd_ready !== 1'b1 || level !== 5'd0) begin
      errors++;
      $display("FAIL mid_release: got ready=%0b level=%0d, required 1 0", upd_ready, level);
    end
  endtask

  initial begin
    test_reset();
    test_basic_batch();
    test_stall();
    test_full_fifo();
    test_empty_commit();
    test_push_commit();
    test_reset_mid_drain();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL final_pending: got %0d pending writes, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
